// File: rtl/pipe_ctrl.sv
// Pipeline hazard / interrupt-entry controller: load-use stall, branch flush, saturating stall counter.
// Define PIPE_CTRL_IRQ_EN to build the IDLE/ARMED/SERVICE interrupt FSM and EPC register.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_req,
  input  logic        ID_eret,
  input  logic [4:0]  ID_RegisterRs,
  input  logic [4:0]  ID_RegisterRt,
  input  logic        EX_MemRd,
  input  logic [4:0]  EX_RegisterRt,
  input  logic        EX_branch_taken,
  input  logic        MEM_isBranch,
  input  logic [31:0] MEM_PC_plus4,
  output logic        stall_PC,
  output logic        stall_IFID,
  output logic        flush_IFID,
  output logic        flush_IDEX,
  output logic        flush_EXMEM,
  output logic        irq_take,
  output logic [31:0] EPC,
  output logic        in_service,
  output logic [15:0] stall_cnt
);

  logic        load_use;
  logic        lu_stall;
  logic        take_w;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  assign load_use = EX_MemRd && (EX_RegisterRt != 5'd0) &&
                    ((EX_RegisterRt == ID_RegisterRs) || (EX_RegisterRt == ID_RegisterRt));

  // Priority: interrupt entry > taken branch > load-use stall.
  assign lu_stall = load_use && !take_w && !EX_branch_taken;

  always_comb begin
    stall_PC    = 1'b0;
    stall_IFID  = 1'b0;
    flush_IFID  = 1'b0;
    flush_IDEX  = 1'b0;
    flush_EXMEM = 1'b0;
    if (take_w) begin
      flush_IFID  = 1'b1;
      flush_IDEX  = 1'b1;
      flush_EXMEM = 1'b1;
    end else if (EX_branch_taken) begin
      flush_IFID = 1'b1;
      flush_IDEX = 1'b1;
    end else if (lu_stall) begin
      stall_PC   = 1'b1;
      stall_IFID = 1'b1;
      flush_IDEX = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (lu_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= 16'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
  assign irq_take  = take_w;

`ifdef PIPE_CTRL_IRQ_EN
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] epc_q, epc_d;

  // Take only while the request is still held and MEM holds no branch (its PC+4 is the resume point).
  assign take_w = reset && (state_q == S_ARMED) && irq_req && !MEM_isBranch && !load_use;

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    case (state_q)
      S_IDLE:    if (irq_req) state_d = S_ARMED;
      S_ARMED: begin
        if (take_w) begin
          state_d = S_SERVICE;
          epc_d   = MEM_PC_plus4;
        end else if (!irq_req) begin
          state_d = S_IDLE;
        end
      end
      S_SERVICE: if (ID_eret) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      epc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
    end
  end

  assign EPC        = epc_q;
  assign in_service = (state_q == S_SERVICE);
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{irq_req, ID_eret, MEM_isBranch, MEM_PC_plus4};
  assign take_w     = 1'b0;
  assign EPC        = 32'd0;
  assign in_service = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: random and directed cycles, expected outputs from a spec-level model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset, irq_req, ID_eret, EX_MemRd, EX_branch_taken, MEM_isBranch;
  logic [4:0]  ID_RegisterRs, ID_RegisterRt, EX_RegisterRt;
  logic [31:0] MEM_PC_plus4;
  logic        stall_PC, stall_IFID, flush_IFID, flush_IDEX, flush_EXMEM, irq_take, in_service;
  logic [31:0] EPC;
  logic [15:0] stall_cnt;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .ID_eret(ID_eret),
    .ID_RegisterRs(ID_RegisterRs), .ID_RegisterRt(ID_RegisterRt),
    .EX_MemRd(EX_MemRd), .EX_RegisterRt(EX_RegisterRt),
    .EX_branch_taken(EX_branch_taken), .MEM_isBranch(MEM_isBranch),
    .MEM_PC_plus4(MEM_PC_plus4),
    .stall_PC(stall_PC), .stall_IFID(stall_IFID), .flush_IFID(flush_IFID),
    .flush_IDEX(flush_IDEX), .flush_EXMEM(flush_EXMEM), .irq_take(irq_take),
    .EPC(EPC), .in_service(in_service), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        s_pc, s_ifid, f_ifid, f_idex, f_exmem, take, insv;
    logic [31:0] epc;
    logic [15:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  // Reference model: interrupt mode is "none", "pending" or "servicing"
  string       m_mode = "none";
  int          m_cnt  = 0;
  logic [31:0] m_epc  = 32'd0;

  task automatic apply(input logic rst, input logic irq, input logic eret,
                       input logic memrd, input logic [4:0] exrt,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic br, input logic isbr, input logic [31:0] pc);
    obs_t e;
    bit lu, take;
    @(posedge clk);
    #1;
    reset = rst; irq_req = irq; ID_eret = eret; EX_MemRd = memrd; EX_RegisterRt = exrt;
    ID_RegisterRs = rs; ID_RegisterRt = rt; EX_branch_taken = br; MEM_isBranch = isbr;
    MEM_PC_plus4 = pc;

    lu = memrd && exrt != 0 && (exrt == rs || exrt == rt);
    take = 1'b0;
`ifdef PIPE_CTRL_IRQ_EN
    take = rst && m_mode == "pending" && irq && !isbr && !lu;
`endif
    e = '0;
    if (take)    begin e.f_ifid = 1; e.f_idex = 1; e.f_exmem = 1; end
    else if (br) begin e.f_ifid = 1; e.f_idex = 1; end
    else if (lu) begin e.s_pc = 1; e.s_ifid = 1; e.f_idex = 1; end
    e.take = take;
    e.insv = (m_mode == "servicing");
    e.epc  = m_epc;
    e.cnt  = 16'(m_cnt);
    exp_q.push_back(e);

    if (!rst) begin
      m_mode = "none"; m_cnt = 0; m_epc = 32'd0;
    end else begin
      if (lu && !take && !br) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
`ifdef PIPE_CTRL_IRQ_EN
      if (m_mode == "none") begin
        if (irq) m_mode = "pending";
      end else if (m_mode == "pending") begin
        if (take) begin m_mode = "servicing"; m_epc = pc; end
        else if (!irq) m_mode = "none";
      end else if (eret) begin
        m_mode = "none";
      end
`endif
    end
  endtask

  task automatic quiet(input logic irq, input logic eret, input logic isbr, input logic [31:0] pc);
    apply(1'b1, irq, eret, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, isbr, pc);
  endtask

  // Monitor: pops one expectation per presented cycle, sampled mid-cycle.
  initial begin : monitor
    obs_t a, e;
    while (!done || exp_q.size() != 0) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = '{stall_PC, stall_IFID, flush_IFID, flush_IDEX, flush_EXMEM, irq_take, in_service,
              EPC, stall_cnt};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs vec %0d: got sPC%b sIF%b fIF%b fID%b fEX%b take%b insv%b epc=%h cnt=%h, want sPC%b sIF%b fIF%b fID%b fEX%b take%b insv%b epc=%h cnt=%h",
                   vectors, a.s_pc, a.s_ifid, a.f_ifid, a.f_idex, a.f_exmem, a.take, a.insv, a.epc, a.cnt,
                   e.s_pc, e.s_ifid, e.f_ifid, e.f_idex, e.f_exmem, e.take, e.insv, e.epc, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    reset = 1'b0; irq_req = 0; ID_eret = 0; EX_MemRd = 0; EX_RegisterRt = 0;
    ID_RegisterRs = 0; ID_RegisterRt = 0; EX_branch_taken = 0; MEM_isBranch = 0; MEM_PC_plus4 = 0;

    // Reset cycles, with a hazard present so combinational outputs are still checked.
    apply(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 32'h0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);

    // Load-use on Rs, then on Rt register zero (no hazard), then load-use plus branch.
    apply(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 32'h0);
    quiet(1'b0, 1'b0, 1'b0, 32'h0);
    apply(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    apply(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 32'h0);
    quiet(1'b0, 1'b0, 1'b0, 32'h0);

    // Interrupt held across three MEM branches, then taken.
    for (int i = 0; i < 3; i++) quiet(1'b1, 1'b0, 1'b1, 32'h0000_0030);
    quiet(1'b1, 1'b0, 1'b0, 32'h0000_0040);
    quiet(1'b1, 1'b0, 1'b0, 32'h0000_0080);
    quiet(1'b0, 1'b0, 1'b0, 32'h0000_0090);
    quiet(1'b1, 1'b0, 1'b0, 32'h0000_00a0);
    // Return, request still high: re-arm.
    quiet(1'b1, 1'b1, 1'b0, 32'h0000_00b0);
    quiet(1'b1, 1'b0, 1'b1, 32'h0000_00c0);
    // Drop request while pending: back to none.
    quiet(1'b0, 1'b0, 1'b0, 32'h0000_00d0);
    quiet(1'b0, 1'b0, 1'b0, 32'h0000_00e0);

    // Random traffic with small register numbers to make hazards frequent.
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
            1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), 1'($urandom), $urandom);
    end

    // Saturate the stall counter, then hold it there.
    apply(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 65540; i++)
      apply(1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 5'd2, 5'd4, 1'b0, 1'b0, 32'h0);
    quiet(1'b0, 1'b0, 1'b0, 32'h0);

    // Enter service, then reset from there.
    quiet(1'b1, 1'b0, 1'b0, 32'h0000_1234);
    quiet(1'b1, 1'b0, 1'b0, 32'h0000_5678);
    quiet(1'b0, 1'b0, 1'b0, 32'h0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    quiet(1'b0, 1'b0, 1'b0, 32'h0);
    quiet(1'b0, 1'b0, 1'b0, 32'h0);

    done = 1'b1;
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-low; sampled only on rising clk.
REQ-003 SHALL have: irq_req  in  1  level-sensitive external interrupt request.
REQ-004 SHALL have: ID_eret  in  1  exception-return decoded in ID.
REQ-005 SHALL have: ID_RegisterRs, ID_RegisterRt  in  5 each  source registers in ID.
REQ-006 SHALL have: EX_MemRd  in  1; EX_RegisterRt  in  5  load in EX and its destination.
REQ-007 SHALL have: EX_branch_taken  in  1  taken branch/jump resolved in EX.
REQ-008 SHALL have: MEM_isBranch  in  1; MEM_PC_plus4  in  32  EX/MEM-register outputs.
REQ-009 SHALL have: stall_PC, stall_IFID  out  1 each  hold PC / IF-ID register.
REQ-010 SHALL have: flush_IFID, flush_IDEX, flush_EXMEM  out  1 each  bubble the next-stage load.
REQ-011 SHALL have: irq_take  out  1; EPC  out  32; in_service  out  1.
REQ-012 SHALL have: stall_cnt  out  16  saturating count of load-use stall cycles.

Function
REQ-013 load_use SHALL be EX_MemRd and EX_RegisterRt != 0 and EX_RegisterRt equals ID_RegisterRs or ID_RegisterRt.
REQ-014 While load_use and not irq_take and not EX_branch_taken: stall_PC=stall_IFID=flush_IDEX=1, others 0; exactly one bubble per hazard.
REQ-015 While EX_branch_taken and not irq_take: flush_IFID=flush_IDEX=1, no stall (branch wins over load_use).
REQ-016 Stall/flush outputs SHALL be combinational from inputs and current state (zero-cycle latency).
REQ-017 FSM states IDLE, ARMED, SERVICE; in_service=1 only in SERVICE.
REQ-018 IDLE -> ARMED when irq_req=1; otherwise stay.
REQ-019 In ARMED, irq_take=1 (combinational) when MEM_isBranch=0 and load_use=0; else wait in ARMED indefinitely.
REQ-020 On irq_take: flush_IFID=flush_IDEX=flush_EXMEM=1, stalls 0; EPC <= MEM_PC_plus4 at that edge; state -> SERVICE.
REQ-021 irq_take SHALL override branch flush and load-use stall in the same cycle; the instruction in MEM completes.
REQ-022 ARMED with irq_req deasserted before take SHALL return to IDLE (no take).
REQ-023 SERVICE ignores irq_req (no nesting); ID_eret=1 -> IDLE on next edge; EPC holds until next take.
REQ-024 stall_cnt increments by 1 each cycle REQ-014 applies; saturates at 16'hFFFF, never wraps.

Reset
REQ-025 With reset=0 at an edge: state=IDLE, EPC=0, stall_cnt=0, regardless of current state (including mid-ARMED/SERVICE).
REQ-026 During reset cycles, combinational stall/flush outputs still follow REQ-013..015; irq_take=0.

Configuration
REQ-027 Macro PIPE_CTRL_IRQ_EN: when defined, REQ-017..023 SHALL be implemented.
REQ-028 Without PIPE_CTRL_IRQ_EN: no FSM or EPC register; irq_take, in_service, flush_EXMEM tied 0; EPC tied 32'h0; irq_req, ID_eret ignored; REQ-013..016, 024 unchanged.

Verification
REQ-029 EX_MemRd=1, EX_RegisterRt=5, ID_RegisterRs=5 for 1 cycle -> stall_PC=stall_IFID=flush_IDEX=1 that cycle; stall_cnt 0->1.
REQ-030 Same with EX_RegisterRt=0 -> all stall/flush 0; stall_cnt unchanged.
REQ-031 Load-use and EX_branch_taken together -> flush_IFID=flush_IDEX=1, stall_PC=0, stall_cnt unchanged.
REQ-032 irq_req=1, MEM_isBranch=1 for 3 cycles then 0, MEM_PC_plus4=32'h0000_0040 -> irq_take exactly on 1st cycle with MEM_isBranch=0; all three flushes 1; EPC=32'h40 next cycle; in_service=1.
REQ-033 In SERVICE, pulse irq_req -> no take; ID_eret=1 -> IDLE next cycle; irq_req still 1 -> ARMED following cycle.
REQ-034 Force 65 540 load-use cycles -> stall_cnt=16'hFFFF, held; reset=0 in SERVICE -> IDLE, EPC=0, stall_cnt=0 next edge.
